// File: rtl/arm_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port, decoder handshake and branch redirect.
// master is the fetch unit side; slave is the memory/decoder/execute environment side.
interface arm_fetch_unit_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_ir;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic        branch_valid;
   logic [31:0] branch_target;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata,
      output fetch_valid,
      output fetch_ir,
      output fetch_pc,
      input  fetch_ready,
      input  branch_valid,
      input  branch_target
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata,
      input  fetch_valid,
      input  fetch_ir,
      input  fetch_pc,
      output fetch_ready,
      output branch_valid,
      output branch_target
   );
endinterface

// File: rtl/arm_fetch_unit.sv
// ARM instruction fetch stage: owns the fetch PC, reads words from instruction memory into a
// small prefetch buffer and presents the head to the decoder; branches flush and redirect.
module arm_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input logic              clk,
   input logic              reset,
   arm_fetch_unit_if.master bus
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   localparam logic [1:0] ST_BOOT     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_REDIRECT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]      head_ir_q, head_ir_d;
   logic [31:0]      head_pc_q, head_pc_d;

   logic [31:0] buf_ir [FIFO_DEPTH];
   logic [31:0] buf_pc [FIFO_DEPTH];

   logic req, push, pop, flush;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign flush = bus.branch_valid;
   assign req   = (state_q == ST_RUN) && (count_q < CNT_FULL) && !bus.branch_valid;
   assign push  = req && bus.mem_ack;
   assign pop   = (count_q != '0) && bus.fetch_ready && !flush;

   always_comb begin
      state_d   = flush ? ST_REDIRECT : ST_RUN;
      pc_d      = pc_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      head_ir_d = head_ir_q;
      head_pc_d = head_pc_q;

      if (flush) begin
         pc_d     = bus.branch_target & ~32'h3;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = ptr_next(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (pop && !push) begin
            count_d = count_q - 1'b1;
         end

         // Head registers track the next head; they hold their value while the buffer is empty.
         if (count_d != '0) begin
            if ((count_q == '0) || (pop && (count_q == CNT_ONE))) begin
               head_ir_d = bus.mem_rdata;
               head_pc_d = pc_q;
            end else begin
               head_ir_d = buf_ir[rd_ptr_d];
               head_pc_d = buf_pc[rd_ptr_d];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_VECTOR;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         head_ir_q <= '0;
         head_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         head_ir_q <= head_ir_d;
         head_pc_q <= head_pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_ir[wr_ptr_q] <= bus.mem_rdata;
         buf_pc[wr_ptr_q] <= pc_q;
      end
   end

   assign bus.mem_req     = req;
   assign bus.mem_addr    = pc_q;
   assign bus.fetch_valid = (count_q != '0);
   assign bus.fetch_ir    = head_ir_q;
   assign bus.fetch_pc    = head_pc_q;

   // A stalled request must keep its address unless a branch withdraws it.
   a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
      (req && !bus.mem_ack) |=> (pc_q == $past(pc_q)));

   a_count_bound: assert property (@(posedge clk) disable iff (!reset)
      count_q <= CNT_FULL);
endmodule
